// File: rtl/return_stack_pkg.sv
// return_stack_pkg: shared defaults, stage encoding and request decode for the return stack
package return_stack_pkg;
  localparam int DEPTH_DEF = 8;
  localparam int AW_DEF = 32;
  localparam logic [2:0] ST_STAGE = 3'd5;
  typedef enum logic [1:0] {OP_IDLE, OP_PUSH, OP_POP, OP_SWAP} op_e;
  function automatic op_e decode_op(input logic w, input logic r, input logic empty, input logic full);
    return (w && r) ? (empty ? OP_PUSH : OP_SWAP) :
           w ? (full ? OP_IDLE : OP_PUSH) :
           r ? (empty ? OP_IDLE : OP_POP) : OP_IDLE;
  endfunction
endpackage

// File: rtl/return_stack_mem.sv
// return_stack_mem: unreset entry storage, one synchronous write port and one combinational read port
module return_stack_mem #(
  parameter int DEPTH = 8,
  parameter int AW = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [AW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [AW-1:0]            rdata
);
  logic [AW-1:0] mem [DEPTH];
  // write the addressed entry on the rising edge
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/return_stack.sv
// return_stack: hardware return-address stack with sticky overflow/underflow and simultaneous pop+push
module return_stack
  import return_stack_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       StW,
  input  logic                       StR,
  input  logic [AW-1:0]              push_addr,
  input  logic                       clr_err,
  output logic [AW-1:0]              ret_addr,
  output logic                       ret_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  op_e           op;
  logic [CW-1:0] count_m1;
  logic [PW-1:0] top_idx;
  logic [PW-1:0] waddr;
  logic          we;
  logic          pops;
  logic          ovf_set;
  logic          unf_set;
  logic [AW-1:0] rd_data;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  // decode the request; a simultaneous pop+push rewrites the top entry in place
  always_comb begin
    op = decode_op(StW, StR, empty, full);
    count_m1 = count - CW'(1);
    top_idx = count_m1[PW-1:0];
    pops = (op == OP_POP) || (op == OP_SWAP);
    we = ((op == OP_PUSH) || (op == OP_SWAP)) && !reset;
    waddr = (op == OP_PUSH) ? count[PW-1:0] : top_idx;
    ovf_set = StW && !StR && full;
    unf_set = StR && empty;
  end
  return_stack_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(push_addr),
    .raddr(top_idx),
    .rdata(rd_data)
  );
  // pointer, popped address and sticky error flags; setting events win over clr_err
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      ret_addr <= '0;
      ret_valid <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count <= (op == OP_PUSH) ? count + CW'(1) : (op == OP_POP) ? count_m1 : count;
      ret_addr <= pops ? rd_data : ret_addr;
      ret_valid <= pops;
      overflow <= ovf_set || (overflow && !clr_err);
      underflow <= unf_set || (underflow && !clr_err);
    end
  end
endmodule

// File: tb/tb_return_stack.sv
// tb_return_stack: scoreboard bench for the return-address stack
module tb_return_stack;
  localparam int DEPTH = 8;
  localparam int AW = 32;
  logic          clk;
  logic          reset;
  logic          StW;
  logic          StR;
  logic [AW-1:0] push_addr;
  logic          clr_err;
  logic [AW-1:0] ret_addr;
  logic          ret_valid;
  logic [3:0]    count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] mstk[$];
  logic [AW-1:0] m_ret = '0;

  return_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .StW      (StW),
    .StR      (StR),
    .push_addr(push_addr),
    .clr_err  (clr_err),
    .ret_addr (ret_addr),
    .ret_valid(ret_valid),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (!reset && ret_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: ret_valid with ret_addr=%h, no pop expected", ret_addr);
      end else begin
        logic [AW-1:0] e;
        e = exp_q.pop_front();
        if (ret_addr !== e) begin
          n_fail++;
          $display("FAIL sb_ret_addr: got %h expected %h", ret_addr, e);
        end
      end
    end
  end

  task automatic drive(input logic w, input logic r, input logic [AW-1:0] a, input logic c);
    StW = w;
    StR = r;
    push_addr = a;
    clr_err = c;
    if (w && r && mstk.size() > 0) begin
      m_ret = mstk[mstk.size()-1];
      exp_q.push_back(m_ret);
      mstk[mstk.size()-1] = a;
    end else if (w && mstk.size() < DEPTH) begin
      mstk.push_back(a);
    end else if (r && !w && mstk.size() > 0) begin
      m_ret = mstk.pop_back();
      exp_q.push_back(m_ret);
    end
    @(posedge clk);
    #1;
    StW = 1'b0;
    StR = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic test_reset;
    n_checks += 6;
    if (count !== 4'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count); end
    if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL rst_empty_full: got %b%b expected 10", empty, full); end
    if (ret_addr !== '0) begin n_fail++; $display("FAIL rst_ret_addr: got %h expected 0", ret_addr); end
    if (ret_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ret_valid: got %b expected 0", ret_valid); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
    if (underflow !== 1'b0) begin n_fail++; $display("FAIL rst_underflow: got %b expected 0", underflow); end
  endtask

  task automatic test_lifo;
    drive(1, 0, 32'h10, 0);
    drive(1, 0, 32'h20, 0);
    drive(1, 0, 32'h30, 0);
    n_checks++;
    if (count !== 4'd3) begin n_fail++; $display("FAIL lifo_count: got %0d expected 3", count); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, '0, 0);
      n_checks++;
      if (ret_valid !== 1'b1) begin n_fail++; $display("FAIL lifo_valid%0d: got %b expected 1", i, ret_valid); end
    end
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL lifo_empty: got %b expected 1", empty); end
    drive(0, 0, '0, 0);
    n_checks += 2;
    if (ret_valid !== 1'b0) begin n_fail++; $display("FAIL lifo_pulse: got %b expected 0", ret_valid); end
    if (ret_addr !== m_ret) begin n_fail++; $display("FAIL lifo_hold: got %h expected %h", ret_addr, m_ret); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < DEPTH; i++) drive(1, 0, 32'h100 + AW'(i), 0);
    n_checks += 2;
    if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b expected 1", full); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", overflow); end
    drive(1, 0, 32'h1FF, 0);
    n_checks += 2;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    if (count !== 4'd8) begin n_fail++; $display("FAIL ovf_count: got %0d expected 8", count); end
    for (int i = 0; i < DEPTH; i++) drive(0, 1, '0, 0);
    n_checks++;
    if (count !== 4'd0) begin n_fail++; $display("FAIL ovf_drain: got %0d expected 0", count); end
    drive(0, 0, '0, 1);
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
  endtask

  task automatic test_underflow;
    drive(0, 1, '0, 0);
    n_checks += 4;
    if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_set: got %b expected 1", underflow); end
    if (ret_valid !== 1'b0) begin n_fail++; $display("FAIL unf_valid: got %b expected 0", ret_valid); end
    if (ret_addr !== m_ret) begin n_fail++; $display("FAIL unf_hold: got %h expected %h", ret_addr, m_ret); end
    if (count !== 4'd0) begin n_fail++; $display("FAIL unf_count: got %0d expected 0", count); end
    drive(0, 0, '0, 1);
    n_checks++;
    if (underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clr: got %b expected 0", underflow); end
  endtask

  task automatic test_swap;
    drive(1, 0, 32'h40, 0);
    drive(1, 0, 32'h50, 0);
    drive(1, 1, 32'h60, 0);
    n_checks += 2;
    if (ret_valid !== 1'b1) begin n_fail++; $display("FAIL swap_valid: got %b expected 1", ret_valid); end
    if (count !== 4'd2) begin n_fail++; $display("FAIL swap_count: got %0d expected 2", count); end
    drive(0, 1, '0, 0);
    drive(0, 1, '0, 0);
    drive(1, 1, 32'h77, 0);
    n_checks += 3;
    if (count !== 4'd1) begin n_fail++; $display("FAIL swap_empty_count: got %0d expected 1", count); end
    if (underflow !== 1'b1) begin n_fail++; $display("FAIL swap_empty_unf: got %b expected 1", underflow); end
    if (ret_valid !== 1'b0) begin n_fail++; $display("FAIL swap_empty_valid: got %b expected 0", ret_valid); end
    drive(0, 1, '0, 1);
    for (int i = 0; i < DEPTH; i++) drive(1, 0, 32'h200 + AW'(i), 0);
    drive(1, 1, 32'h2AA, 0);
    n_checks += 2;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL swap_full_ovf: got %b expected 0", overflow); end
    if (count !== 4'd8) begin n_fail++; $display("FAIL swap_full_count: got %0d expected 8", count); end
    drive(1, 0, 32'h2BB, 1);
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_collision: got %b expected 1", overflow); end
    for (int i = 0; i < DEPTH; i++) drive(0, 1, '0, 0);
    drive(0, 0, '0, 1);
  endtask

  task automatic test_async_reset;
    drive(1, 0, 32'hAA, 0);
    n_checks++;
    if (ret_addr === '0) begin n_fail++; $display("FAIL arst_pre: got %h expected nonzero", ret_addr); end
    #2 reset = 1'b1;
    #1;
    n_checks += 3;
    if (count !== 4'd0) begin n_fail++; $display("FAIL arst_count: got %0d expected 0", count); end
    if (ret_addr !== '0) begin n_fail++; $display("FAIL arst_ret_addr: got %h expected 0", ret_addr); end
    if (empty !== 1'b1) begin n_fail++; $display("FAIL arst_empty: got %b expected 1", empty); end
    mstk.delete();
    m_ret = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    drive(0, 1, '0, 0);
    n_checks++;
    if (ret_valid !== 1'b0 || underflow !== 1'b1) begin n_fail++; $display("FAIL arst_pop_empty: got valid=%b unf=%b expected 0 1", ret_valid, underflow); end
  endtask

  initial begin
    reset = 1'b1;
    StW = 1'b0;
    StR = 1'b0;
    push_addr = '0;
    clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    test_lifo();
    test_overflow();
    test_underflow();
    test_swap();
    test_async_reset();
    repeat (2) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_pending: got %0d outstanding expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/return_stack.md
RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 Parameter: DEPTH, 8, number of return-address entries (power of two, >=2).
REQ-002 Parameter: AW, 32, return-address width in bits.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: StW  input  1  push request from control unit (JAL in ST stage).
REQ-006 Port: StR  input  1  pop request from control unit (stop-bit return in ST stage).
REQ-007 Port: push_addr  input  AW  return address to push (PC+1 from PC adder).
REQ-008 Port: ret_addr  output  AW  registered last-popped address, consumed by PC mux (PCsrc=0).
REQ-009 Port: ret_valid  output  1  one-cycle pulse, ret_addr updated this cycle.
REQ-010 Port: count  output  clog2(DEPTH+1)  current number of stored entries.
REQ-011 Port: empty  output  1  count==0 (combinational from count).
REQ-012 Port: full  output  1  count==DEPTH (combinational from count).
REQ-013 Port: overflow  output  1  sticky: push attempted while full.
REQ-014 Port: underflow  output  1  sticky: pop attempted while empty.
REQ-015 Port: clr_err  input  1  synchronous clear of overflow and underflow.

Function
REQ-016 Push only (StW=1, StR=0, not full) SHALL write push_addr to entry[count] and increment count, visible next cycle.
REQ-017 Pop only (StR=1, StW=0, not empty) SHALL load ret_addr with entry[count-1], decrement count, and pulse ret_valid for exactly one cycle.
REQ-018 Pop latency SHALL be one cycle: ret_addr valid the cycle after StR sampled high.
REQ-019 ret_addr SHALL hold its value between pops; no other event changes it except reset.
REQ-020 Push while full SHALL be dropped: contents and count unchanged, overflow set.
REQ-021 Pop while empty SHALL be ignored: ret_addr, count unchanged, ret_valid stays 0, underflow set.
REQ-022 StW and StR together, not empty: SHALL pop (ret_addr<=top, ret_valid=1) and overwrite the same entry with push_addr; count unchanged.
REQ-023 StW and StR together, empty: SHALL behave as push only and set underflow.
REQ-024 StW and StR together, full: SHALL behave per REQ-022 (no overflow).
REQ-025 clr_err SHALL clear both sticky flags; a setting event in the same cycle SHALL win over clr_err.
REQ-026 count SHALL never exceed DEPTH or wrap below 0.
REQ-027 Inputs StW/StR SHALL be treated as level-sampled each edge; a request held N cycles acts N times.

Reset
REQ-028 On reset assertion (asynchronous): count=0, ret_addr=0, ret_valid=0, overflow=0, underflow=0; empty=1, full=0.
REQ-029 Entry storage SHALL NOT be reset; entries are unreadable until pushed.
REQ-030 Reset asserted mid-sequence SHALL abandon any same-cycle push/pop; no partial update.

Structure
REQ-031 Shared package SHALL hold DEPTH and AW defaults and the ST_STAGE encoding (5) shared with the control unit.
REQ-032 Storage SHALL be a sub-module return_stack_mem (DEPTH x AW, one synchronous write port, one combinational read port); pointer, flags and ret_addr logic stay in return_stack.

Verification
REQ-033 Reset, push 0x10, 0x20, 0x30, pop x3 -> ret_addr 0x30, 0x20, 0x10 on successive cycles, ret_valid pulse each, empty=1 after.
REQ-034 Push 8 values 0x100..0x107, push 0x1FF -> full=1, overflow=1, count=8; pop -> ret_addr=0x107.
REQ-035 From empty, pop -> underflow=1, ret_valid=0, ret_addr unchanged; clr_err -> underflow=0.
REQ-036 Stack holds 0x40,0x50; StW=StR=1 with push_addr=0x60 -> ret_addr=0x50, count=2; next pop -> ret_addr=0x60.
REQ-037 Push 0xAA, assert reset between clock edges -> count=0, ret_addr=0 immediately, before next edge.
REQ-038 Overflow event coincident with clr_err=1 -> overflow=1 after edge.
